lp_bus_encoder: RTL and testbench

Parametrised low-transition bus encoder. It is the successor to the fixed 32-bit four-mode Hamming encoder.

- Each accepted word of `DATA_W` bits is encoded with one of five transforms.
- The transform chosen is the one whose result has the minimum Hamming distance to the word currently driven on the bus.
- The 3-bit transform code is appended to the word, and the result is registered onto the bus behind a valid/ready handshake.
- It sits between the AHB write-data path and the off-block interconnect, and keeps transition statistics for power characterisation.

---
 rtl/lp_bus_encoder.sv | 123 ++++++++++++
 tb/tb_lp_bus_encoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/lp_bus_encoder.sv
// lp_bus_encoder: low-transition bus encoder. Each accepted word is sent as the
//   candidate transform (pass/invert/swap/inv-even/inv-odd) that lies at minimum
//   Hamming distance to the word on the bus. The 3-bit code is appended.
// Latency: 1 cycle from accept to out_data/out_valid.
// Backpressure: in_ready = !out_valid || out_ready, so a held word stalls input.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   in_data/valid/ready  payload input handshake
//   mode_en[3:0]         enables for codes 1..4 (pass is always enabled)
//   out_data/valid/ready encoded bus word {payload', code} and its handshake
//   stat_clr             clears word_cnt/hd_sum (an accept in the same cycle reloads them)
//   word_cnt, hd_sum     saturating count of accepted words and sum of chosen distances
module lp_bus_encoder #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        mode_en,
  output logic [DATA_W+2:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  hd_sum
);

  localparam int BUS_W = DATA_W + 3;
  localparam int HD_W  = $clog2(BUS_W + 1);
  // One spare bit over the wider operand so the saturation test can see the carry.
  localparam int SUM_W = ((CNT_W > HD_W) ? CNT_W : HD_W) + 1;

  localparam logic [DATA_W-1:0] EVEN_MASK = {(DATA_W/2){2'b01}};
  localparam logic [DATA_W-1:0] ODD_MASK  = {(DATA_W/2){2'b10}};
  localparam logic [SUM_W-1:0]  CNT_MAX   = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  function automatic logic [HD_W-1:0] popcnt(input logic [BUS_W-1:0] v);
    logic [HD_W-1:0] c;
    c = '0;
    for (int i = 0; i < BUS_W; i++) c = c + HD_W'(v[i]);
    return c;
  endfunction

  logic [DATA_W-1:0] swapped;
  logic [BUS_W-1:0]  cand [5];
  logic [HD_W-1:0]   hd   [5];
  logic [BUS_W-1:0]  best_word;
  logic [HD_W-1:0]   best_hd;
  logic              accept;
  logic [SUM_W-1:0]  wc_base, wc_sum, hs_base, hs_sum;
  logic [CNT_W-1:0]  wc_next, hs_next;

  always_comb begin
    swapped = '0;
    for (int k = 0; k < DATA_W/2; k++) begin
      swapped[2*k]   = in_data[2*k+1];
      swapped[2*k+1] = in_data[2*k];
    end
  end

  assign cand[0] = {in_data,             3'd0};
  assign cand[1] = {~in_data,            3'd1};
  assign cand[2] = {swapped,             3'd2};
  assign cand[3] = {in_data ^ EVEN_MASK, 3'd3};
  assign cand[4] = {in_data ^ ODD_MASK,  3'd4};

  // Distance is measured against the register itself, consumed or not.
  always_comb begin
    for (int i = 0; i < 5; i++) hd[i] = popcnt(cand[i] ^ out_data);
  end

  // Strict '<' in ascending code order gives the lowest code on ties.
  always_comb begin
    best_word = cand[0];
    best_hd   = hd[0];
    for (int i = 1; i < 5; i++) begin
      if (mode_en[i-1] && (hd[i] < best_hd)) begin
        best_word = cand[i];
        best_hd   = hd[i];
      end
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A clear in the accept cycle starts the counters from zero, so they load
  // the increment of that word.
  always_comb begin
    wc_base = stat_clr ? '0 : SUM_W'(word_cnt);
    hs_base = stat_clr ? '0 : SUM_W'(hd_sum);
    wc_sum  = wc_base + SUM_W'(1);
    hs_sum  = hs_base + SUM_W'(best_hd);
    wc_next = (wc_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : wc_sum[CNT_W-1:0];
    hs_next = (hs_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : hs_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      word_cnt  <= '0;
      hd_sum    <= '0;
    end else begin
      if (accept) begin
        out_data  <= best_word;
        out_valid <= 1'b1;
        word_cnt  <= wc_next;
        hd_sum    <= hs_next;
      end else begin
        if (out_valid && out_ready) out_valid <= 1'b0;
        if (stat_clr) begin
          word_cnt <= '0;
          hd_sum   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lp_bus_encoder.sv
// tb_lp_bus_encoder: directed scenarios plus random regression against a
//   behavioural model of the encoder (DATA_W = 8, CNT_W = 4).
module tb_lp_bus_encoder;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  mode_en;
  logic [10:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        stat_clr;
  logic [3:0]  word_cnt;
  logic [3:0]  hd_sum;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [10:0] m_bus;
  logic        m_vld;
  int          m_wc;
  int          m_hs;

  lp_bus_encoder #(.DATA_W(8), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode_en(mode_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .stat_clr(stat_clr), .word_cnt(word_cnt), .hd_sum(hd_sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Candidate for a code, written from the transform definitions.
  function automatic logic [10:0] make_cand(input logic [7:0] x, input int code);
    logic [7:0] p;
    case (code)
      0:       p = x;
      1:       p = ~x;
      2:       p = ((x & 8'hAA) >> 1) | ((x & 8'h55) << 1);
      3:       p = x ^ 8'h55;
      default: p = x ^ 8'hAA;
    endcase
    return {p, 3'(code)};
  endfunction

  task automatic pick(input logic [7:0] x, input logic [3:0] en, input logic [10:0] bus,
                      output logic [10:0] win, output int win_hd);
    int d;
    logic [10:0] c;
    win    = make_cand(x, 0);
    win_hd = $countones(win ^ bus);
    for (int code = 1; code <= 4; code++) begin
      if (en[code-1]) begin
        c = make_cand(x, code);
        d = $countones(c ^ bus);
        if (d < win_hd) begin
          win    = c;
          win_hd = d;
        end
      end
    end
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // One clock: drive inputs, check in_ready, step the model, check outputs after the edge.
  task automatic cycle(input logic rn, input logic iv, input logic [7:0] d,
                       input logic [3:0] en, input logic ordy, input logic clr);
    logic        acc;
    logic [10:0] w;
    int          h;
    resetn = rn; in_valid = iv; in_data = d; mode_en = en; out_ready = ordy; stat_clr = clr;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_vld || ordy));
    acc = rn && iv && (!m_vld || ordy);
    pick(d, en, m_bus, w, h);
    @(posedge clk);
    if (!rn) begin
      m_bus = '0; m_vld = 1'b0; m_wc = 0; m_hs = 0;
    end else if (acc) begin
      m_bus = w; m_vld = 1'b1;
      m_wc = sat15((clr ? 0 : m_wc) + 1);
      m_hs = sat15((clr ? 0 : m_hs) + h);
    end else begin
      if (m_vld && ordy) m_vld = 1'b0;
      if (clr) begin m_wc = 0; m_hs = 0; end
    end
    #1;
    chk("out_data",  32'(out_data),  32'(m_bus));
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    chk("word_cnt",  32'(word_cnt),  32'(m_wc));
    chk("hd_sum",    32'(hd_sum),    32'(m_hs));
  endtask

  initial begin
    logic [10:0] held;
    m_bus = '0; m_vld = 1'b0; m_wc = 0; m_hs = 0;
    resetn = 1'b0; in_valid = 1'b0; in_data = '0; mode_en = '0; out_ready = 1'b0; stat_clr = 1'b0;
    @(posedge clk); #1;

    // Reset then first word
    cycle(1'b0, 1'b0, 8'h00, 4'hF, 1'b1, 1'b0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    cycle(1'b1, 1'b1, 8'hFF, 4'hF, 1'b1, 1'b0);
    chk("first_out_data", 32'(out_data), 32'h001);
    chk("first_hd_sum",   32'(hd_sum),   32'd1);
    chk("first_word_cnt", 32'(word_cnt), 32'd1);
    // Follow-on word
    cycle(1'b1, 1'b1, 8'h00, 4'hF, 1'b1, 1'b0);
    chk("follow_out_data", 32'(out_data), 32'h000);
    chk("follow_hd_sum",   32'(hd_sum),   32'd2);

    // Mode masking
    cycle(1'b0, 1'b0, 8'h00, 4'hF, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 8'hFF, 4'b1110, 1'b0, 1'b0);
    chk("mask_out_data", 32'(out_data), 32'h2AC);
    chk("mask_hd_sum",   32'(hd_sum),   32'd5);

    // Backpressure: out_valid=1, out_ready=0, in_valid=1 for 5 cycles
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 8'h3C, 4'hF, 1'b0, 1'b0);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_held",     32'(out_data), 32'(held));
      chk("bp_word_cnt", 32'(word_cnt), 32'd1);
    end
    cycle(1'b1, 1'b1, 8'h3C, 4'hF, 1'b1, 1'b0);
    chk("bp_release_valid", 32'(out_valid), 32'h1);
    chk("bp_release_cnt",   32'(word_cnt),  32'd2);

    // Saturation
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 8'(i * 37), 4'hF, 1'b1, 1'b0);
    chk("sat_word_cnt", 32'(word_cnt), 32'd15);
    chk("sat_hd_sum",   32'(hd_sum),   32'd15);
    // stat_clr with accept
    cycle(1'b1, 1'b1, 8'h5A, 4'hF, 1'b1, 1'b1);
    chk("clr_acc_word_cnt", 32'(word_cnt), 32'd1);
    // stat_clr without accept
    cycle(1'b1, 1'b0, 8'h00, 4'hF, 1'b1, 1'b1);
    chk("clr_word_cnt", 32'(word_cnt), 32'd0);
    // Reset mid-stream
    cycle(1'b1, 1'b1, 8'hC3, 4'hF, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'hC3, 4'hF, 1'b0, 1'b0);
    chk("midrst_out_data",  32'(out_data),  32'h0);
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_word_cnt",  32'(word_cnt),  32'h0);
    chk("midrst_hd_sum",    32'(hd_sum),    32'h0);

    // Random regression
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 499) != 0),
            ($urandom_range(0, 3) != 0),
            8'($urandom),
            4'($urandom),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
